// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Register map and activation-type encoding for npu_act_engine.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    localparam logic [31:0] c_ADDR_TYPE   = 32'h0000_0000;
    localparam logic [31:0] c_ADDR_INPUT  = 32'h0000_0004;
    localparam logic [31:0] c_ADDR_OUTPUT = 32'h0000_0008;
    localparam logic [31:0] c_ADDR_STATUS = 32'h0000_000C;

    typedef enum logic [1:0] {
        ACT_ID    = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_SAT   = 2'd3
    } act_type_e;

endpackage
`default_nettype wire

// File: rtl/npu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : npu_sync_fifo
// Description : Single-clock FIFO; a push into a full FIFO is accepted when a
//               pop happens in the same cycle, a pop only ever sees old data.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned    c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL    = DEPTH[c_AW:0];
    localparam logic [c_AW:0]  c_CNT_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_AW-1:0] c_PTR_ONE = {{(c_AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/npu_act_engine.sv
`default_nettype none
// ============================================================================
// Module      : npu_act_engine
// Description : Register-mapped activation engine: input FIFO -> compute
//               stage -> output FIFO with sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_act_engine
    import npu_pkg::*;
#(
    parameter int unsigned DWidth     = 32,
    parameter int unsigned FifoDepth  = 8,
    parameter int unsigned LeakyShift = 3,
    parameter int          SatMax     = 6 << 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wen_type_i,
    input  logic              wen_input_i,
    input  logic              ren_i,
    input  logic [DWidth-1:0] addr_i,
    input  logic [DWidth-1:0] wdata_i,
    output logic [DWidth-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              irq_o
);

    localparam int unsigned             c_CW      = $clog2(FifoDepth) + 1;
    localparam int unsigned             c_IW      = DWidth + 2;
    localparam logic signed [DWidth-1:0] c_SAT_MAX = DWidth'(SatMax);

    act_type_e                 r_type;
    logic                      r_ovf;
    logic                      r_udf;
    logic                      r_cmp_valid;
    logic [DWidth-1:0]         r_cmp_data;
    logic [DWidth-1:0]         r_rdata;
    logic                      r_rvalid;

    logic                      w_sel_type;
    logic                      w_sel_output;
    logic                      w_sel_status;

    logic                      w_in_push;
    logic                      w_in_pop;
    logic [c_IW-1:0]           w_in_wdata;
    logic [c_IW-1:0]           w_in_head;
    logic                      w_in_full;
    logic                      w_in_empty;
    logic [c_CW-1:0]           w_in_count;

    logic                      w_out_push;
    logic                      w_out_pop;
    logic                      w_out_room;
    logic [DWidth-1:0]         w_out_wdata;
    logic [DWidth-1:0]         w_out_head;
    logic                      w_out_full;
    logic                      w_out_empty;
    logic [c_CW-1:0]           w_out_count;

    act_type_e                 w_head_type;
    logic signed [DWidth-1:0]  w_head_data;
    logic signed [DWidth-1:0]  w_act;
    logic                      w_cmp_load;
    logic                      w_busy;
    logic                      w_set_ovf;
    logic                      w_set_udf;
    logic                      w_clr_flags;
    logic [DWidth-1:0]         w_status;
    logic [DWidth-1:0]         w_rd_mux;

    assign w_sel_type   = (addr_i == DWidth'(c_ADDR_TYPE));
    assign w_sel_output = (addr_i == DWidth'(c_ADDR_OUTPUT));
    assign w_sel_status = (addr_i == DWidth'(c_ADDR_STATUS));

    // Each element carries the type that was current when it was pushed.
    assign w_in_wdata = {r_type, wdata_i};
    assign w_in_push  = wen_input_i && !w_in_full;
    assign w_set_ovf  = wen_input_i && w_in_full;

    npu_sync_fifo #(
        .WIDTH (c_IW),
        .DEPTH (FifoDepth)
    ) u_in_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_in_push),
        .i_pop   (w_in_pop),
        .i_wdata (w_in_wdata),
        .o_rdata (w_in_head),
        .o_full  (w_in_full),
        .o_empty (w_in_empty),
        .o_count (w_in_count)
    );

    assign w_head_type = act_type_e'(w_in_head[DWidth+1:DWidth]);
    assign w_head_data = w_in_head[DWidth-1:0];

    always_comb begin
        w_act = w_head_data;
        case (w_head_type)
            ACT_ID:    w_act = w_head_data;
            ACT_RELU:  w_act = w_head_data[DWidth-1] ? '0 : w_head_data;
            ACT_LEAKY: w_act = w_head_data[DWidth-1] ? (w_head_data >>> LeakyShift) : w_head_data;
            ACT_SAT: begin
                if (w_head_data[DWidth-1])        w_act = '0;
                else if (w_head_data > c_SAT_MAX) w_act = c_SAT_MAX;
                else                              w_act = w_head_data;
            end
            default:   w_act = w_head_data;
        endcase
    end

    // The compute register drains first to keep order; when empty and the
    // output FIFO has room, the result goes straight through in one cycle.
    assign w_out_pop   = ren_i && w_sel_output && !w_out_empty;
    assign w_out_room  = !w_out_full || w_out_pop;
    assign w_out_push  = w_out_room && (r_cmp_valid || !w_in_empty);
    assign w_out_wdata = r_cmp_valid ? r_cmp_data : w_act;
    assign w_in_pop    = !w_in_empty && (!r_cmp_valid || w_out_room);
    assign w_cmp_load  = w_in_pop && (r_cmp_valid || !w_out_room);

    npu_sync_fifo #(
        .WIDTH (DWidth),
        .DEPTH (FifoDepth)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_out_push),
        .i_pop   (w_out_pop),
        .i_wdata (w_out_wdata),
        .o_rdata (w_out_head),
        .o_full  (w_out_full),
        .o_empty (w_out_empty),
        .o_count (w_out_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmp_valid <= 1'b0;
            r_cmp_data  <= '0;
        end else if (w_cmp_load) begin
            r_cmp_valid <= 1'b1;
            r_cmp_data  <= w_act;
        end else if (r_cmp_valid && w_out_room) begin
            r_cmp_valid <= 1'b0;
        end
    end

    assign w_busy      = !w_in_empty || !w_out_empty || r_cmp_valid;
    assign w_set_udf   = ren_i && w_sel_output && w_out_empty;
    assign w_clr_flags = wen_type_i && w_sel_status;

    always_comb begin
        w_status        = '0;
        w_status[31:24] = 8'(w_in_count);
        w_status[23:16] = 8'(w_out_count);
        w_status[2]     = w_busy;
        w_status[1]     = r_udf;
        w_status[0]     = r_ovf;
    end

    // A flag set in the same cycle as its W1C clear stays set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_type <= ACT_ID;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (wen_type_i && w_sel_type) r_type <= act_type_e'(wdata_i[1:0]);
            r_ovf <= w_set_ovf || (r_ovf && !(w_clr_flags && wdata_i[0]));
            r_udf <= w_set_udf || (r_udf && !(w_clr_flags && wdata_i[1]));
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_sel_type)                         w_rd_mux[1:0] = r_type;
        else if (w_sel_output && !w_out_empty)  w_rd_mux = w_out_head;
        else if (w_sel_status)                  w_rd_mux = w_status;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= ren_i;
            if (ren_i) r_rdata <= w_rd_mux;
        end
    end

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;
    assign irq_o    = !w_out_empty;

endmodule
`default_nettype wire

// File: tb/tb_npu_act_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_act_engine
// Description : Directed self-checking bench for npu_act_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_act_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen_type;
    logic        wen_input;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    npu_act_engine #(
        .DWidth     (32),
        .FifoDepth  (8),
        .LeakyShift (3),
        .SatMax     (6 << 8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wen_type_i  (wen_type),
        .wen_input_i (wen_input),
        .ren_i       (ren),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .irq_o       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wen_type = 1'b1; addr = a; wdata = d;
        tick();
        wen_type = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic push(input logic [31:0] d);
        wen_input = 1'b1; wdata = d;
        tick();
        wen_input = 1'b0; wdata = '0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ren = 1'b1; addr = a;
        tick();
        ren = 1'b0; addr = '0;
        chk(tag, rdata, exp);
        chk({tag, "_vld"}, {31'b0, rvalid}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; wen_type = 1'b0; wen_input = 1'b0;
        ren = 1'b1; addr = 32'hC; wdata = '0;
        tick();
        tick();
        chk("rst_rdata",  rdata, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_irq",    {31'b0, irq}, 32'h0);
        ren = 1'b0; addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd("rst_status", 32'hC, 32'h0);
        rd("rst_type",   32'h0, 32'h0);
        tick();
        chk("rvalid_pulse", {31'b0, rvalid}, 32'h0);

        // Identity latency: readable exactly two cycles after the push.
        push(32'h0000_1234);
        chk("irq_after_push", {31'b0, irq}, 32'h0);
        tick();
        chk("irq_before_read", {31'b0, irq}, 32'h1);
        rd("lat_id", 32'h8, 32'h0000_1234);
        rd("lat_status", 32'hC, 32'h0);

        // ReLU
        wr(32'h0, 32'd1);
        push(32'hFFFF_FFFB);
        push(32'd7);
        rd("relu_neg", 32'h8, 32'h0);
        rd("relu_pos", 32'h8, 32'd7);
        rd("relu_status", 32'hC, 32'h0);
        chk("irq_empty", {31'b0, irq}, 32'h0);
        rd("type_rb", 32'h0, 32'd1);

        // Leaky and per-element type latching
        wr(32'h0, 32'd2);
        push(32'hFFFF_FFC0);
        wr(32'h0, 32'd0);
        push(32'hFFFF_FFC0);
        rd("leaky_m64", 32'h8, 32'hFFFF_FFF8);
        rd("id_m64",    32'h8, 32'hFFFF_FFC0);
        wr(32'h0, 32'd2);
        push(32'hFFFF_FFBF);
        push(32'd40);
        rd("leaky_m65", 32'h8, 32'hFFFF_FFF7);
        rd("leaky_pos", 32'h8, 32'd40);

        // TYPE write and push in the same cycle: the push uses the old type.
        wr(32'h0, 32'd0);
        wen_type = 1'b1; wen_input = 1'b1; addr = 32'h0; wdata = 32'hFFFF_FFFF;
        tick();
        wen_type = 1'b0; wen_input = 1'b0; addr = '0; wdata = '0;
        push(32'hFFFF_FFFF);
        rd("same_cyc_old", 32'h8, 32'hFFFF_FFFF);
        rd("same_cyc_new", 32'h8, 32'h0);
        rd("type_sat_rb",  32'h0, 32'd3);

        // Saturating
        push(32'h0000_0700);
        push(32'h0000_0100);
        push(32'h0000_0600);
        rd("sat_clamp", 32'h8, 32'h0000_0600);
        rd("sat_pass",  32'h8, 32'h0000_0100);
        rd("sat_edge",  32'h8, 32'h0000_0600);

        // Unmapped accesses
        rd("unmapped_rd", 32'h10, 32'h0);
        wr(32'h10, 32'd1);
        rd("unmapped_wr", 32'h0, 32'd3);

        // Overflow: 2*8+2 pushes, 2*8+1 survive
        wr(32'h0, 32'd0);
        for (int i = 0; i < 18; i++) push(32'h100 + i);
        chk("full_irq", {31'b0, irq}, 32'h1);
        rd("full_status", 32'hC, 32'h0808_0005);
        for (int i = 0; i < 17; i++) rd($sformatf("drain%0d", i), 32'h8, 32'h100 + i);
        rd("drained_status", 32'hC, 32'h0000_0001);

        // Underflow and W1C
        rd("udf_read", 32'h8, 32'h0);
        rd("udf_status", 32'hC, 32'h0000_0003);
        wr(32'hC, 32'h1);
        rd("w1c_ovf", 32'hC, 32'h0000_0002);
        wr(32'hC, 32'h2);
        rd("w1c_udf", 32'hC, 32'h0);

        // Mid-stream reset
        wr(32'h0, 32'd1);
        push(32'h11);
        push(32'h22);
        push(32'h33);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ren = 1'b1; addr = 32'hC; wen_input = 1'b1; wdata = 32'hFFFF_FFF0;
        tick();
        ren = 1'b0; addr = '0; wen_input = 1'b0; wdata = '0;
        chk("post_rst_status", rdata, 32'h0);
        tick();
        rd("post_rst_word", 32'h8, 32'hFFFF_FFF0);
        rd("post_rst_empty", 32'h8, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npu_act_engine.md
NPU_ACT_ENGINE -- requirements
Module: npu_act_engine

Interface
REQ-001 SHALL have parameter DWidth, default 32, meaning data and address width in bits.
REQ-002 SHALL have parameter FifoDepth, default 8, meaning entries per input and output FIFO; power of two, at least 2.
REQ-003 SHALL have parameter LeakyShift, default 3, meaning arithmetic right shift applied to negatives in leaky-ReLU mode.
REQ-004 SHALL have parameter SatMax, default 6<<8, meaning the upper clamp in saturating-ReLU mode.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: the reset; asynchronous, active-low.
REQ-007 SHALL have port wen_type_i, input, 1 bit: write strobe for the type register.
REQ-008 SHALL have port wen_input_i, input, 1 bit: write strobe that pushes one input word.
REQ-009 SHALL have port ren_i, input, 1 bit: read strobe.
REQ-010 SHALL have port addr_i, input, DWidth bits: register address.
REQ-011 SHALL have port wdata_i, input, DWidth bits: write data.
REQ-012 SHALL have port rdata_o, output, DWidth bits: registered read data.
REQ-013 SHALL have port rvalid_o, output, 1 bit: rdata_o is valid this cycle.
REQ-014 SHALL have port irq_o, output, 1 bit: the output FIFO is non-empty.

Function
REQ-015 Address map: TYPE=0x0 (RW, bits[1:0]); INPUT=0x4 (W); OUTPUT=0x8 (R, pops); STATUS=0xC (R; W1C on bits[1:0]).
REQ-016 Activation type: 0 identity; 1 ReLU (max(x,0)); 2 leaky (x>=0 ? x : x>>>LeakyShift); 3 saturating (min(max(x,0),SatMax)); all values signed two's complement, DWidth bits.
REQ-017 A push SHALL store {type, data}, so each element uses the type current at push time; a TYPE write in the same cycle as a push SHALL NOT affect that push.
REQ-018 Pipeline: input FIFO -> one compute register stage -> output FIFO; a word pushed in cycle t SHALL become poppable in cycle t+2 when no stall is present.
REQ-019 The compute stage SHALL hold its value (stall) while its output is valid and the output FIFO is full; no element SHALL be lost or duplicated.
REQ-020 A push while the input FIFO is full SHALL be dropped and SHALL set the sticky flag STATUS[0] (overflow).
REQ-021 A read of OUTPUT while the output FIFO is empty SHALL return 0 with rvalid_o=1 and SHALL set the sticky flag STATUS[1] (underflow).
REQ-022 A simultaneous push and pop on the same FIFO SHALL succeed even when that FIFO is full (output side) or empty (input side, via bypass-free ordering: the pop sees the old contents).
REQ-023 Reads SHALL have a latency of 1: ren_i in cycle t gives rdata_o/rvalid_o in t+1; rvalid_o SHALL be a single-cycle pulse per read.
REQ-024 STATUS SHALL read {in_count, out_count, busy, udf, ovf}: in_count at [31:24], out_count at [23:16], busy at [2], udf at [1], ovf at [0]. busy = any FIFO non-empty OR compute stage valid.
REQ-025 A read of an unmapped address SHALL return 0 with rvalid_o=1; a write to an unmapped address SHALL be ignored.
REQ-026 FIFO pointers SHALL wrap modulo FifoDepth; counts SHALL range from 0 to FifoDepth inclusive.

Reset
REQ-027 While rst_ni=0: TYPE=0, both FIFOs empty, compute stage invalid, flags cleared, rdata_o=0, rvalid_o=0, irq_o=0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight elements immediately; the first cycle after release SHALL accept a push.

Structure
REQ-029 Package npu_pkg SHALL hold the address constants TYPE/INPUT/OUTPUT/STATUS and the enum act_type_e {ACT_ID, ACT_RELU, ACT_LEAKY, ACT_SAT}.
REQ-030 Sub-module npu_sync_fifo (parameters: width and depth; push, pop, full, empty and count ports) SHALL be instantiated twice: an input FIFO of width DWidth+2 and an output FIFO of width DWidth.

Verification
REQ-031 Set TYPE=1; push -5, 7 -> reads of OUTPUT return 0, then 7; the first result is readable 2 cycles after its push.
REQ-032 Set TYPE=2, LeakyShift=3; push -64; set TYPE=0; push -64 -> reads return -8, then -64 (type is latched per element).
REQ-033 Set TYPE=3; push 0x700, 0x100 -> reads return 0x600, then 0x100.
REQ-034 Push 2*FifoDepth+2 words with no reads -> STATUS.ovf=1 and in_count=out_count=FifoDepth; draining yields exactly 2*FifoDepth+1 words, in order.
REQ-035 Read OUTPUT while the output FIFO is empty -> rdata_o=0, udf=1; write STATUS with value 0x3 -> udf=ovf=0.
REQ-036 Push 3 words, then assert rst_ni low for 1 cycle -> STATUS reads 0, irq_o=0; a new push followed by a read returns the new word only.
